register_command_sequencer: RTL
===============================

Name: register_command_sequencer

Overview:
- Initiator that drives the E / FunSel / I command interface of a 16-bit register.
- Accepts one high-level request through a valid/ready handshake and expands it into a timed sequence of single-cycle register commands: full load, byte-wise load, clear, N-fold increment/decrement, clear-then-count.
- Sits between the control unit and a register instance, so the control unit no longer generates per-cycle FunSel sequences.

Parameters:
- WIDTH, 16, data width of ReqData and I.
- CNT_W, 8, width of ReqCount (repeat count for INC_N / DEC_N / CLR_INC).

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  sequencer can accept a request; equals (state==IDLE) & ~Reset.
- ReqOp  input  3  operation code, sampled at the handshake.
- ReqData  input  WIDTH  operand, sampled at the handshake.
- ReqCount  input  CNT_W  repeat count, sampled at the handshake.
- E  output  1  register enable; registered.
- FunSel  output  3  register function select; registered.
- I  output  WIDTH  register data input; registered.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse when a request completes.
- Err  output  1  one-cycle pulse with Done for a reserved ReqOp.

Behaviour:
- Handshake: accept on a rising edge where ReqValid & ReqReady. ReqOp, ReqData and ReqCount are latched internally and may change afterwards.
- FunSel codes emitted: 000 dec, 001 inc, 010 load, 011 clear, 101 write low byte, 110 write high byte.
- ReqOp decode (steps = number of E cycles):
  - 000 LOAD16: 1 step, FunSel=010, I=ReqData.
  - 001 CLEAR: 1 step, FunSel=011, I=0.
  - 010 LOAD_BYTES: 2 steps.
    - Step 1: FunSel=101, I={8'h00, ReqData[7:0]}.
    - Step 2: FunSel=110, I={8'h00, ReqData[15:8]}.
  - 011 INC_N: ReqCount steps of FunSel=001, I=0.
  - 100 DEC_N: ReqCount steps of FunSel=000, I=0.
  - 101 CLR_INC: 1 step FunSel=011, then ReqCount steps of FunSel=001 (total ReqCount+1).
  - 110, 111: reserved. Zero steps; Done and Err pulse together.
- FSM states IDLE, RUN:
  - IDLE: ReqReady=1, E=0.
    - Accept with steps>0 -> RUN. First step appears on E/FunSel/I in the cycle after the accept edge.
    - Accept with steps==0 (INC_N/DEC_N with count 0, reserved op) -> stay IDLE. Done pulses in the cycle after the accept edge, with no E cycle.
  - RUN: Busy=1, ReqReady=0, E=1 for exactly `steps` consecutive cycles. A down-counter of width CNT_W+1 tracks remaining steps, so count 255 plus the clear step is legal.
    - After the last step -> IDLE. In that cycle E=0, Done=1, ReqReady=1.
- Back-to-back requests: a request accepted in the Done cycle starts its first step in the next cycle. Minimum gap between E bursts is 1 cycle.
- Whenever E=0: FunSel=000 and I=0. Outputs are deterministic and E gates all register effect.
- Done and Err are high for exactly one cycle per request and never high in RUN.
- Reset (highest priority):
  - Next state is IDLE.
  - E=0, FunSel=000, I=0, Busy=0, Done=0, Err=0, counters=0.
  - ReqReady=0 while Reset is high; no request is accepted during reset.
  - Reset mid-RUN aborts: E drops at the next edge, remaining steps are discarded, and no Done is issued for the aborted request.
- ReqValid while not ready: ignored; ReqValid does not need to be held stable by the requester.

Test Plan:
- Reset with ReqValid=1 for 2 cycles -> E=0, Done=0, ReqReady=0 during reset. First accept happens on the first edge after Reset drops.
- LOAD16 ReqData=16'hBEEF -> one cycle later E=1, FunSel=010, I=BEEF for 1 cycle. Next cycle Done=1, Err=0. Modelled register Q=BEEF.
- LOAD_BYTES ReqData=16'h12AB:
  - Cycle+1: FunSel=101, I=00AB.
  - Cycle+2: FunSel=110, I=0012.
  - Cycle+3: Done. Register model (starting from 0) Q=12AB.
- CLR_INC ReqCount=5 on register holding 0x7777 -> 6 consecutive E cycles (011 then 5×001), then Done. Q=0005. INC_N ReqCount=0 -> zero E cycles, Done in the cycle after accept.
- DEC_N ReqCount=3 from Q=0001 -> 3 E cycles FunSel=000, Q=FFFE (wrap-around). Then a back-to-back LOAD16 accepted in the Done cycle starts E in the very next cycle.
- Reserved ReqOp=110 -> no E, Done=1 and Err=1 same cycle. Separately, Reset asserted during step 2 of an INC_N ReqCount=10 -> E=0 from next cycle, Done never pulses for that request.

Source files
------------

// File: rtl/register_command_sequencer.sv
// Expands one valid/ready request into a timed burst of single-cycle E/FunSel/I
// commands for a 16-bit register: load, byte load, clear, N-fold inc/dec, clear-then-count.
module register_command_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [2:0]       ReqOp,
   input  logic [WIDTH-1:0] ReqData,
   input  logic [CNT_W-1:0] ReqCount,
   output logic             E,
   output logic [2:0]       FunSel,
   output logic [WIDTH-1:0] I,
   output logic             Busy,
   output logic             Done,
   output logic             Err
);

   localparam logic [2:0] OP_LOAD16     = 3'b000;
   localparam logic [2:0] OP_CLEAR      = 3'b001;
   localparam logic [2:0] OP_LOAD_BYTES = 3'b010;
   localparam logic [2:0] OP_INC_N      = 3'b011;
   localparam logic [2:0] OP_DEC_N      = 3'b100;
   localparam logic [2:0] OP_CLR_INC    = 3'b101;

   localparam logic [2:0] FS_DEC   = 3'b000;
   localparam logic [2:0] FS_INC   = 3'b001;
   localparam logic [2:0] FS_LOAD  = 3'b010;
   localparam logic [2:0] FS_CLEAR = 3'b011;
   localparam logic [2:0] FS_WR_LO = 3'b101;
   localparam logic [2:0] FS_WR_HI = 3'b110;

   localparam logic [CNT_W:0] STEP_ZERO = '0;
   localparam logic [CNT_W:0] STEP_ONE  = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] STEP_TWO  = (CNT_W+1)'(2);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] data_reg;
   logic [CNT_W:0]   remain_reg;

   logic [CNT_W:0]   steps;
   logic [2:0]       first_fs;
   logic [WIDTH-1:0] first_i;
   logic [2:0]       follow_fs;
   logic [WIDTH-1:0] follow_i;
   logic             reserved_op;

   assign ReqReady    = (state_reg == IDLE) & ~Reset;
   assign reserved_op = ReqOp[2] & ReqOp[1];

   // Step count and first command of the incoming request.
   always_comb begin
      steps    = STEP_ZERO;
      first_fs = FS_DEC;
      first_i  = '0;
      case (ReqOp)
         OP_LOAD16: begin
            steps    = STEP_ONE;
            first_fs = FS_LOAD;
            first_i  = ReqData;
         end
         OP_CLEAR: begin
            steps    = STEP_ONE;
            first_fs = FS_CLEAR;
         end
         OP_LOAD_BYTES: begin
            steps    = STEP_TWO;
            first_fs = FS_WR_LO;
            first_i  = WIDTH'(ReqData[7:0]);
         end
         OP_INC_N: begin
            steps    = {1'b0, ReqCount};
            first_fs = FS_INC;
         end
         OP_DEC_N: begin
            steps    = {1'b0, ReqCount};
            first_fs = FS_DEC;
         end
         OP_CLR_INC: begin
            steps    = {1'b0, ReqCount} + STEP_ONE;
            first_fs = FS_CLEAR;
         end
         default: begin
            steps    = STEP_ZERO;
            first_fs = FS_DEC;
         end
      endcase
   end

   // Every step after the first is the same command, except the high-byte write.
   always_comb begin
      follow_fs = FS_INC;
      follow_i  = '0;
      case (op_reg)
         OP_LOAD_BYTES: begin
            follow_fs = FS_WR_HI;
            follow_i  = WIDTH'(data_reg[15:8]);
         end
         OP_DEC_N: follow_fs = FS_DEC;
         default:  follow_fs = FS_INC;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg  <= IDLE;
         op_reg     <= '0;
         data_reg   <= '0;
         remain_reg <= '0;
         E          <= 1'b0;
         FunSel     <= FS_DEC;
         I          <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Err        <= 1'b0;
      end else begin
         E      <= 1'b0;
         FunSel <= FS_DEC;
         I      <= '0;
         Done   <= 1'b0;
         Err    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ReqValid) begin
                  op_reg   <= ReqOp;
                  data_reg <= ReqData;
                  if (steps == STEP_ZERO) begin
                     Done <= 1'b1;
                     Err  <= reserved_op;
                  end else begin
                     state_reg  <= RUN;
                     Busy       <= 1'b1;
                     E          <= 1'b1;
                     FunSel     <= first_fs;
                     I          <= first_i;
                     remain_reg <= steps - STEP_ONE;
                  end
               end
            end
            RUN: begin
               if (remain_reg == STEP_ZERO) begin
                  state_reg <= IDLE;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
               end else begin
                  remain_reg <= remain_reg - STEP_ONE;
                  E          <= 1'b1;
                  FunSel     <= follow_fs;
                  I          <= follow_i;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
